mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory with one-cycle read latency.
// Read responses are steered back to the port that issued them.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          lp_q;
  logic          pend_valid_q;
  logic          pend_port_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  // Under contention the port that did not win last time gets the memory.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        gnt0 = lp_q;
        gnt1 = ~lp_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = (gnt0 & we0) | (gnt1 & we1);
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end
  end

  // Masking with rst drops a response whose read was granted just before reset.
  always_comb begin
    rvalid0 = pend_valid_q & ~pend_port_q & ~rst;
    rvalid1 = pend_valid_q & pend_port_q & ~rst;
    rdata0  = rvalid0 ? mem_rdata : rdata0_q;
    rdata1  = rvalid1 ? mem_rdata : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lp_q         <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_port_q  <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      if (mem_en) begin
        lp_q <= gnt1;
      end
      pend_valid_q <= mem_en & ~mem_we;
      pend_port_q  <= gnt1;
      if (rvalid0) begin
        rdata0_q <= mem_rdata;
      end
      if (rvalid1) begin
        rdata1_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model with its own memory image.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory stub attached to the DUT: 16 words indexed by addr[5:2], one-cycle read latency.
  logic [DW-1:0] mem_tb [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_tb[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= mem_tb[mem_addr[5:2]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the memory this cycle, what answer is owed next cycle.
  logic [DW-1:0] mem_m [16];
  bit            lp_m = 1'b1;
  bit            owe_m = 1'b0;
  bit            owe_port_m = 1'b0;
  logic [DW-1:0] owe_data_m = '0;
  logic [DW-1:0] last_m [2] = '{default: '0};
  bit            g0_m, g1_m;
  int            win, wait0 = 0, wait1 = 0;
  bit            e_rv0, e_rv1;
  logic [DW-1:0] e_rd0, e_rd1;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  bit            ww;

  always @(negedge clk) begin
    win = -1;
    if (!rst) begin
      if (req0 && req1) win = lp_m ? 0 : 1;
      else if (req0)    win = 0;
      else if (req1)    win = 1;
    end
    g0_m = (win == 0);
    g1_m = (win == 1);
    wa = (win == 1) ? addr1 : addr0;
    wd = (win == 1) ? wdata1 : wdata0;
    ww = (win == 1) ? we1 : we0;
    chk("gnt0", gnt0, g0_m);
    chk("gnt1", gnt1, g1_m);
    chk("mem_en", mem_en, win >= 0);
    if (win >= 0) begin
      chk("mem_we", mem_we, ww);
      chk("mem_addr", mem_addr, wa);
      chk("mem_wdata", mem_wdata, wd);
    end else begin
      chk("mem_we_idle", mem_we, 1'b0);
    end
    e_rv0 = !rst && owe_m && !owe_port_m;
    e_rv1 = !rst && owe_m && owe_port_m;
    e_rd0 = e_rv0 ? owe_data_m : last_m[0];
    e_rd1 = e_rv1 ? owe_data_m : last_m[1];
    chk("rvalid0", rvalid0, e_rv0);
    chk("rvalid1", rvalid1, e_rv1);
    chk("rdata0", rdata0, e_rd0);
    chk("rdata1", rdata1, e_rd1);
    // Starvation bound judged from the DUT's own grants.
    if (!rst && req0 && !gnt0) wait0++; else wait0 = 0;
    if (!rst && req1 && !gnt1) wait1++; else wait1 = 0;
    chk("wait0_bound", wait0 <= 1, 1'b1);
    chk("wait1_bound", wait1 <= 1, 1'b1);
    if (e_rv0) last_m[0] = e_rd0;
    if (e_rv1) last_m[1] = e_rd1;
    if (rst) begin
      lp_m = 1'b1;
      owe_m = 1'b0;
      owe_port_m = 1'b0;
      last_m[0] = '0;
      last_m[1] = '0;
    end else begin
      owe_m = 1'b0;
      if (win >= 0) begin
        lp_m = (win == 1);
        if (ww) begin
          mem_m[wa[5:2]] = wd;
        end else begin
          owe_m = 1'b1;
          owe_port_m = (win == 1);
          owe_data_m = mem_m[wa[5:2]];
        end
      end
    end
  end

  task automatic step(input bit rs, input bit r0, input bit w0, input logic [31:0] a0,
                      input logic [31:0] d0, input bit r1, input bit w1, input logic [31:0] a1,
                      input logic [31:0] d1);
    @(posedge clk);
    #1;
    rst = rs; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
  endtask

  bit            hr0 = 0, hw0 = 0, hr1 = 0, hw1 = 0, rs_r;
  logic [31:0]   ha0 = 0, hd0 = 0, ha1 = 0, hd1 = 0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_tb[i] = $urandom;
      mem_m[i]  = mem_tb[i];
    end
    mem_tb[4] = 32'hDEADBEEF;
    mem_m[4]  = 32'hDEADBEEF;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h10, 0, 1, 0, 32'h14, 0);
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_rdata0", rdata0, 32'h0);

    // Single read of 0xDEADBEEF from 0x10.
    step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("rd_gnt0", gnt0, 1'b1);
    chk("rd_mem_addr", mem_addr, 32'h10);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_rvalid0", rvalid0, 1'b1);
    chk("rd_rdata0", rdata0, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_hold_rvalid0", rvalid0, 1'b0);
    chk("rd_hold_rdata0", rdata0, 32'hDEADBEEF);

    // Contention after reset: grants 0,1,0,1 with responses one cycle behind.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
      chk("cont_gnt0", gnt0, (k % 2) == 0);
      chk("cont_gnt1", gnt1, (k % 2) == 1);
      chk("cont_rvalid0", rvalid0, (k % 2) == 1);
      chk("cont_rvalid1", rvalid1, (k > 0) && ((k % 2) == 0));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("cont_last_rvalid1", rvalid1, 1'b1);

    // Write from port 1.
    step(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h5);
    chk("wr_gnt1", gnt1, 1'b1);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 32'h20);
    chk("wr_mem_wdata", mem_wdata, 32'h5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wr_no_rvalid1", rvalid1, 1'b0);

    // Reset right after a read grant drops the response.
    step(0, 0, 0, 0, 0, 1, 0, 32'h8, 0);
    chk("rr_gnt1", gnt1, 1'b1);
    step(1, 0, 0, 0, 0, 1, 0, 32'h8, 0);
    chk("rr_rvalid1", rvalid1, 1'b0);
    chk("rr_gnt1_in_rst", gnt1, 1'b0);
    chk("rr_mem_en", mem_en, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rr_rvalid1_after", rvalid1, 1'b0);
    chk("rr_rdata1_after", rdata1, 32'h0);

    // Lone requester on port 1; pointer stays 1, so port 0 then wins contention.
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 1, 0, 32'hC, 0);
      chk("solo_gnt1", gnt1, 1'b1);
    end
    step(0, 1, 0, 32'h18, 0, 1, 0, 32'h1C, 0);
    chk("solo_then_cont_gnt0", gnt0, 1'b1);

    // Idle cycles keep the pointer at 0, so port 1 wins the next contention.
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("idle_mem_en", mem_en, 1'b0);
    end
    step(0, 1, 0, 32'h18, 0, 1, 0, 32'h1C, 0);
    chk("idle_then_cont_gnt1", gnt1, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic; requests are held until granted.
    for (int n = 0; n < 3000; n++) begin
      if (!hr0 || g0_m) begin
        hr0 = ($urandom % 3) != 0; hw0 = $urandom % 2; ha0 = $urandom; hd0 = $urandom;
      end
      if (!hr1 || g1_m) begin
        hr1 = ($urandom % 3) != 0; hw1 = $urandom % 2; ha1 = $urandom; hd1 = $urandom;
      end
      rs_r = ($urandom % 60) == 0;
      step(rs_r, hr0, hw0, ha0, hd0, hr1, hw1, ha1, hd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
